// File: rtl/alu_mdu_seq_if.sv
// Purpose: request/response bundle between a requester and alu_mdu_seq.
// Latency: none, wires only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
// Ports: master = requester (drives operands, select, flush, out_ready);
//        slave  = alu_mdu_seq (drives in_ready, out_valid, res, zero, negative).
interface alu_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [4:0]      alu_sel;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            zero;
  logic            negative;

  modport master (
    output in_valid, op1, op2, alu_sel, flush, out_ready,
    input  in_ready, out_valid, res, zero, negative
  );

  modport slave (
    input  in_valid, op1, op2, alu_sel, flush, out_ready,
    output in_ready, out_valid, res, zero, negative
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// Purpose: sequential ALU with iterative multiply (shift-add) and restoring divide.
// Latency: result valid 1 edge after accept for ALU ops and div bypass cases, XLEN+1 edges
//          (counting the accept edge) for multiply/divide.
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst_n (async, active-low); bus (slave modport) carries the request
//        handshake, operands, select, flush, and the registered result and flags.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mdu_seq_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;        // magnitude of op1
  logic [XLEN-1:0]   b_q, b_d;        // magnitude of op2
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [1:0]        fn_q, fn_d;      // variant within the mul or div group
  logic              sgn_q, sgn_d;    // negate product / quotient at the end
  logic              rsgn_q, rsgn_d;  // negate remainder at the end

  // ---------------- request decode ----------------
  logic [XLEN-1:0] op1, op2, diff, alu_res;
  logic [SHW-1:0]  shamt;
  logic [4:0]      sel;
  logic            is_mul, is_div, op1_signed, op2_signed, s1, s2;
  logic            div_zero, div_ovf;

  assign op1   = bus.op1;
  assign op2   = bus.op2;
  assign sel   = bus.alu_sel;
  assign shamt = op2[SHW-1:0];
  assign diff  = op1 - op2;

  assign is_mul = (sel[4:2] == 3'b100);
  assign is_div = (sel[4:2] == 3'b101);

  // MULH: both signed; MULHSU: op1 signed only; DIV/REM (even codes): both signed.
  assign op1_signed = (is_mul && (sel[1:0] == 2'b01 || sel[1:0] == 2'b10)) || (is_div && !sel[0]);
  assign op2_signed = (is_mul && (sel[1:0] == 2'b01)) || (is_div && !sel[0]);
  assign s1 = op1_signed & op1[XLEN-1];
  assign s2 = op2_signed & op2[XLEN-1];

  assign div_zero = (op2 == '0);
  assign div_ovf  = !sel[0] && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);

  always_comb begin
    alu_res = '0;
    unique case (sel)
      5'b00000: alu_res = op1 + op2;
      5'b00001: alu_res = op1 - op2;
      5'b00010: alu_res = op2;
      5'b00011: alu_res = op1 << shamt;
      5'b00100: alu_res = op1 >> shamt;
      5'b00101: alu_res = $unsigned($signed(op1) >>> shamt);
      5'b00110: alu_res = op1 ^ op2;
      5'b00111: alu_res = op1 | op2;
      5'b01000: alu_res = op1 & op2;
      5'b01001: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      default:  alu_res = '0;
    endcase
  end

  // ---------------- iteration datapath ----------------
  // Multiply walks the multiplier MSB-first: shift the partial product left, add the
  // multiplicand when the current bit is set.
  logic [2*XLEN-1:0] p_step, p_fin;
  assign p_step = {prod_q[2*XLEN-2:0], 1'b0} + (b_q[cnt_q] ? {{XLEN{1'b0}}, a_q} : '0);
  assign p_fin  = sgn_q ? -p_step : p_step;

  // Restoring divide: bring down one dividend bit, subtract when it fits.
  logic [XLEN:0]   r_sh, r_sub;
  logic            ge;
  logic [XLEN-1:0] r_new, quo_new, q_fin, r_fin;
  assign r_sh  = {rem_q, a_q[cnt_q]};
  assign r_sub = r_sh - {1'b0, b_q};
  assign ge    = (r_sh >= {1'b0, b_q});
  assign r_new = ge ? r_sub[XLEN-1:0] : r_sh[XLEN-1:0];

  always_comb begin
    quo_new         = quo_q;
    quo_new[cnt_q]  = ge;
  end

  assign q_fin = sgn_q  ? -quo_new : quo_new;
  assign r_fin = rsgn_q ? -r_new   : r_new;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    fn_d    = fn_q;
    sgn_d   = sgn_q;
    rsgn_d  = rsgn_q;

    if (bus.flush) begin
      // Abort wins over accept and over the result handshake.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            zero_d = (diff == '0);
            neg_d  = diff[XLEN-1];
            fn_d   = sel[1:0];
            a_d    = s1 ? -op1 : op1;
            b_d    = s2 ? -op2 : op2;
            sgn_d  = s1 ^ s2;
            rsgn_d = s1;
            prod_d = '0;
            rem_d  = '0;
            quo_d  = '0;
            if (is_mul) begin
              state_d = MUL;
              cnt_d   = CW'(XLEN - 1);
            end else if (is_div && div_zero) begin
              res_d   = sel[1] ? op1 : '1;
              state_d = DONE;
            end else if (is_div && div_ovf) begin
              res_d   = sel[1] ? '0 : op1;
              state_d = DONE;
            end else if (is_div) begin
              state_d = DIV;
              cnt_d   = CW'(XLEN - 1);
            end else begin
              res_d   = alu_res;
              state_d = DONE;
            end
          end
        end
        MUL: begin
          prod_d = p_step;
          if (cnt_q == '0) begin
            res_d   = (fn_q == 2'b00) ? p_fin[XLEN-1:0] : p_fin[2*XLEN-1:XLEN];
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DIV: begin
          rem_d = r_new;
          quo_d = quo_new;
          if (cnt_q == '0) begin
            res_d   = fn_q[1] ? r_fin : q_fin;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      fn_q    <= '0;
      sgn_q   <= 1'b0;
      rsgn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      fn_q    <= fn_d;
      sgn_q   <= sgn_d;
      rsgn_q  <= rsgn_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Purpose: randomized and directed checking of alu_mdu_seq against an arithmetic model.
// Latency: measures edges from accept (accept edge = 1) to the first out_valid.
// Backpressure: holds out_ready low for random/fixed cycles and probes ignored requests.
module tb_alu_mdu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_mdu_seq_if #(.XLEN(32)) bus ();

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res;
  logic        exp_zero, exp_neg;
  bit          exp_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    logic [63:0] pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (s)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return b;
      5'd3:  return a << b[4:0];
      5'd4:  return a >> b[4:0];
      5'd5:  return $unsigned($signed(a) >>> b[4:0]);
      5'd6:  return a ^ b;
      5'd7:  return a | b;
      5'd8:  return a & b;
      5'd9:  return (ia < ib) ? 32'd1 : 32'd0;
      5'd16: begin p = ua * ub; pv = p; return pv[31:0]; end
      5'd17: begin p = sa * sb; pv = p; return pv[63:32]; end
      5'd18: begin p = sa * ub; pv = p; return pv[63:32]; end
      5'd19: begin p = ua * ub; pv = p; return pv[63:32]; end
      5'd20: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
    if (s >= 5'd16 && s <= 5'd19) return 33;
    if (s >= 5'd20 && s <= 5'd23) begin
      if (b == 0) return 1;
      if (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return 1;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Result monitor: every cycle the DUT claims a result, it must be the expected one.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      checks++;
      if (!exp_pending) begin
        errors++;
        $display("FAIL spurious_out_valid: got 1, expected 0");
      end else begin
        chk("res", bus.res, exp_res);
        chk("zero", 32'(bus.zero), 32'(exp_zero));
        chk("negative", 32'(bus.negative), 32'(exp_neg));
      end
      chk("in_ready_with_out_valid", 32'(bus.in_ready), 32'd0);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                        input int hold, input bit rel_rst, input bit use_lit, input logic [31:0] lit);
    int n;
    logic [31:0] d;
    @(negedge clk);
    exp_res  = model(a, b, s);
    d        = a - b;
    exp_zero = (d == 0);
    exp_neg  = d[31];
    if (rel_rst) rst_n = 1'b1;
    bus.op1      = a;
    bus.op2      = b;
    bus.alu_sel  = s;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_pending  = 1'b1;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(model_lat(a, b, s)));
    if (use_lit) chk("directed_res", bus.res, lit);
    for (int i = 0; i < hold; i++) begin
      chk("in_ready_during_hold", 32'(bus.in_ready), 32'd0);
      bus.op1      = $urandom();
      bus.op2      = $urandom();
      bus.alu_sel  = 5'($urandom_range(0, 9));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    exp_pending   = 1'b0;
    bus.out_ready = 1'b0;
    chk("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_res"},       bus.res,            32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd0);
    chk({tag, "_negative"},  32'(bus.negative),  32'd0);
  endtask

  // Start a DIV, abort it 10 edges after accept (accept edge = 1) by flush or reset.
  task automatic abort_div(input bit use_rst);
    @(negedge clk);
    bus.op1       = 32'd1000;
    bus.op2       = 32'd7;
    bus.alu_sel   = 5'd20;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    if (!use_rst) begin
      @(negedge clk);
      bus.flush    = 1'b1;
      // A simultaneous request must lose to flush.
      bus.op1      = 32'd1;
      bus.op2      = 32'd1;
      bus.alu_sel  = 5'd0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("flush_idle_after_wait", 32'(bus.in_ready), 32'd1);
    end else begin
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.alu_sel   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");

    // Directed cases with hand-computed results; first one also releases reset.
    run_op(32'd6, 32'd5, 5'd0, 0, 1'b1, 1'b1, 32'd11);
    run_op(32'h8000_0000, 32'd2, 5'd17, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(-32'sd7, 32'd2, 5'd20, 0, 1'b0, 1'b1, 32'hFFFF_FFFD);
    run_op(-32'sd7, 32'd2, 5'd22, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(32'd7, 32'd0, 5'd21, 0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 0, 1'b0, 1'b1, 32'h8000_0000);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 0, 1'b0, 1'b1, 32'd0);
    run_op(32'd5, 32'd5, 5'd1, 0, 1'b0, 1'b1, 32'd0);
    run_op(32'd12345, 32'd678, 5'd16, 5, 1'b0, 1'b1, 32'd8369910);
    run_op(32'd3, 32'd9, 5'd9, 5, 1'b0, 1'b1, 32'd1);
    run_op(32'd3, 32'd9, 5'd30, 0, 1'b0, 1'b1, 32'd0);

    abort_div(1'b0);
    run_op(32'h8000_0000, 32'd35, 5'd5, 0, 1'b0, 1'b1, 32'hF000_0000);
    abort_div(1'b1);
    run_op(32'h8000_0000, 32'd35, 5'd5, 0, 1'b1, 1'b1, 32'hF000_0000);

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a, b;
      logic [4:0]  s;
      a = rnd_op();
      b = rnd_op();
      s = 5'($urandom_range(0, 31));
      run_op(a, b, s, $urandom_range(0, 3), 1'b0, 1'b0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_mdu_seq.md
ALU_MDU_SEQ -- requirements
Module: alu_mdu_seq

Interface
REQ-001 Parameter XLEN, default 32, meaning operand/result width; SHALL be a power of two, at least 8.
REQ-002 Parameter SHW, default $clog2(XLEN), meaning the number of shift-amount bits taken from op2.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 op1  input  XLEN  operand 1.
REQ-008 op2  input  XLEN  operand 2.
REQ-009 alu_sel  input  5  operation select.
REQ-010 flush  input  1  synchronous abort of the in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 res  output  XLEN  registered result.
REQ-014 zero  output  1  registered flag: (op1-op2)==0, from the accepted operands.
REQ-015 negative  output  1  registered flag: MSB of (op1-op2), from the accepted operands.

Function
REQ-016 State machine SHALL have four states: IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 Accept SHALL occur on a clk edge with in_valid&&in_ready; op1, op2, alu_sel and both flags SHALL be captured at accept.
REQ-018 Encodings 00000-01001 SHALL select the single-cycle operations:
- add, sub
- pass op2
- sll, srl, sra (shift amount = op2[SHW-1:0])
- xor, or, and
- signed set-less-than (zero-extended 1/0)
REQ-019 Encodings 10000-10011 SHALL select MUL, MULH, MULHSU, MULHU, and 10100-10111 SHALL select DIV, DIVU, REM, REMU, with RV32M semantics generalised to XLEN.
REQ-020 Any other encoding SHALL produce res=0 as a single-cycle operation.
REQ-021 For single-cycle operations, the FSM SHALL go IDLE->DONE at the accept edge, so out_valid is high in the cycle after accept.
REQ-022 Multiply SHALL be iterative shift-add over a 2*XLEN product, one bit per cycle, with a counter from XLEN-1 down to 0:
- signed operands SHALL be converted to magnitudes and the sign applied at the end
- FSM SHALL go IDLE->MUL->DONE, with out_valid rising exactly XLEN+1 edges after accept
REQ-023 Divide SHALL be restoring, one quotient bit per cycle, with the same counter, sign handling and latency as multiply, via IDLE->DIV->DONE.
REQ-024 Divide by zero SHALL bypass iteration and go IDLE->DONE:
- quotient = all ones
- remainder = op1
REQ-025 Signed overflow (op1 = most-negative, op2 = -1) for DIV/REM SHALL bypass iteration and go IDLE->DONE:
- quotient = op1
- remainder = 0
REQ-026 In DONE, out_valid SHALL be 1 and res, zero and negative SHALL hold stable until out_ready=1.
REQ-027 The out_valid&&out_ready edge SHALL return the FSM to IDLE; back-to-back accept SHALL occur no earlier than the following edge.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state and drop the result (out_valid=0).
REQ-029 flush SHALL take priority over accept and over the out_ready handshake.
REQ-030 All arithmetic SHALL wrap modulo 2^XLEN except the internal 2*XLEN product.
REQ-031 in_ready and out_valid SHALL never both be 1.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for clk, force the following, regardless of the current state:
- state = IDLE
- in_ready = 1
- out_valid = 0
- res = 0, zero = 0, negative = 0
- counter = 0
REQ-033 Reset deassertion SHALL permit an accept on the first following rising edge.

Verification
REQ-034 ADD: op1=6, op2=5, sel=00000 -> one cycle later out_valid=1, res=11, zero=0, negative=0.
REQ-035 MULH (XLEN=32): op1=0x80000000, op2=2, sel=10001 -> out_valid after exactly 33 edges, res=0xFFFFFFFF.
REQ-036 DIV: op1=-7, op2=2 -> res=-3; REM with the same operands -> res=-1; DIVU op1=7, op2=0 -> res=0xFFFFFFFF, out_valid after 1 edge.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles after DONE -> res stable, in_ready=0, new in_valid ignored.
REQ-038 Flush or rst_n pulse at cycle 10 of a DIV -> out_valid never rises for it; next SRA op1=0x80000000, op2=35 -> res=0xF0000000.
